// File: rtl/vga_timing_pkg.sv
// Timing constants shared with the 640x480 generator, plus the tracker state
// encoding and the sync polarity helper used by the tracker and its edge detector.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = 525;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } trk_state_e;

    // Returns 1 when the raw pin is at its asserted level.
    function automatic logic sync_level(input logic raw, input logic active_high);
        return active_high ? raw : ~raw;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Normalises one sync input to active-high, keeps one sample of history and
// flags the leading (asserting) edge of the current sample.
module sync_edge_detect
    import vga_timing_pkg::*;
#(
    parameter bit POL = 1'b0
) (
    input  logic pclk,
    input  logic rst,
    input  logic sync_in,
    output logic rise
);

    logic level;
    logic prev_q;
    logic prev_d;

    always_comb begin
        level  = sync_level(sync_in, POL);
        prev_d = level;
        rise   = level & ~prev_q;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/vga_sync_tracker.sv
// Recovers active-area x/y from an hsync/vsync pair, measures line and frame
// lengths and only reports lock after LOCK_FRAMES consecutive clean frames.
module vga_sync_tracker
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2,
    parameter int WIDTH       = 10
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             hsync,
    input  logic             vsync,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             active,
    output logic             frame_start,
    output logic             locked,
    output logic             sync_err,
    output logic [WIDTH-1:0] h_meas,
    output logic [WIDTH-1:0] v_meas
);

    localparam logic [WIDTH-1:0] CNT_MAX     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] H_START     = WIDTH'(H_SYNC + H_BP);
    localparam logic [WIDTH-1:0] H_STOP      = WIDTH'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [WIDTH-1:0] V_START     = WIDTH'(V_SYNC + V_BP);
    localparam logic [WIDTH-1:0] V_STOP      = WIDTH'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [WIDTH-1:0] H_NOM       = WIDTH'(H_TOTAL);
    localparam logic [WIDTH-1:0] V_NOM       = WIDTH'(V_TOTAL);
    localparam logic [7:0]       GOOD_TARGET = 8'(LOCK_FRAMES);

    logic             h_edge;
    logic             vs_lvl;
    logic             f_edge;
    logic [WIDTH-1:0] hinc;
    logic [WIDTH-1:0] vinc;
    logic             sat_fail;
    logic             line_fail;
    logic             frame_pass;
    logic [7:0]       good_next;
    logic             in_h;
    logic             in_v;

    trk_state_e       state_q, state_d;
    logic [7:0]       good_q, good_d;
    logic             clean_q, clean_d;
    logic             vs_at_h_q, vs_at_h_d;
    logic [WIDTH-1:0] hpos_q, hpos_d;
    logic [WIDTH-1:0] vpos_q, vpos_d;
    logic [WIDTH-1:0] h_meas_q, h_meas_d;
    logic [WIDTH-1:0] v_meas_q, v_meas_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             active_q, active_d;
    logic             frame_start_q, frame_start_d;
    logic             locked_q, locked_d;
    logic             sync_err_q, sync_err_d;

    sync_edge_detect #(
        .POL (SYNC_POL)
    ) u_hsync_edge (
        .pclk    (pclk),
        .rst     (rst),
        .sync_in (hsync),
        .rise    (h_edge)
    );

    // Position counters and measurements; vsync is only qualified at H-edges.
    always_comb begin
        vs_lvl     = sync_level(vsync, SYNC_POL);
        f_edge     = h_edge & vs_lvl & ~vs_at_h_q;
        vs_at_h_d  = h_edge ? vs_lvl : vs_at_h_q;
        hinc       = (hpos_q == CNT_MAX) ? CNT_MAX : hpos_q + 1'b1;
        vinc       = (vpos_q == CNT_MAX) ? CNT_MAX : vpos_q + 1'b1;
        hpos_d     = h_edge ? '0 : hinc;
        vpos_d     = f_edge ? '0 : (h_edge ? vinc : vpos_q);
        h_meas_d   = h_edge ? hinc : h_meas_q;
        v_meas_d   = f_edge ? vinc : v_meas_q;
        sat_fail   = ~h_edge & (hpos_q != CNT_MAX) & (hinc == CNT_MAX);
        line_fail  = (h_edge & (hinc != H_NOM)) | sat_fail;
        // A line failing on the F-edge itself belongs to the frame that is ending.
        frame_pass = (vinc == V_NOM) & clean_q & ~line_fail;
        good_next  = good_q + 8'd1;
    end

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        clean_d    = clean_q;
        sync_err_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (f_edge) begin
                    state_d = MEASURE;
                    good_d  = 8'd0;
                    clean_d = 1'b1;
                end
            end
            MEASURE: begin
                if (f_edge) begin
                    clean_d = 1'b1;
                    if (!frame_pass) begin
                        good_d = 8'd0;
                    end else if (good_next >= GOOD_TARGET) begin
                        state_d = LOCKED;
                        good_d  = 8'd0;
                    end else begin
                        good_d = good_next;
                    end
                end else if (line_fail) begin
                    clean_d = 1'b0;
                end
            end
            LOCKED: begin
                if (f_edge) begin
                    clean_d = 1'b1;
                    if (!frame_pass) begin
                        state_d    = MEASURE;
                        good_d     = 8'd0;
                        sync_err_d = 1'b1;
                    end
                end else if (line_fail) begin
                    state_d    = MEASURE;
                    good_d     = 8'd0;
                    clean_d    = 1'b0;
                    sync_err_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = 8'd0;
                clean_d = 1'b0;
            end
        endcase
    end

    // Outputs describe the sample just taken, so they are built from the _d values.
    always_comb begin
        locked_d      = (state_d == LOCKED);
        in_h          = (hpos_d >= H_START) && (hpos_d < H_STOP);
        in_v          = (vpos_d >= V_START) && (vpos_d < V_STOP);
        active_d      = locked_d & in_h & in_v;
        x_d           = active_d ? hpos_d - H_START : '0;
        y_d           = active_d ? vpos_d - V_START : '0;
        frame_start_d = f_edge;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= SEARCH;
            good_q        <= 8'd0;
            clean_q       <= 1'b0;
            vs_at_h_q     <= 1'b0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            h_meas_q      <= '0;
            v_meas_q      <= '0;
            x_q           <= '0;
            y_q           <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            clean_q       <= clean_d;
            vs_at_h_q     <= vs_at_h_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            h_meas_q      <= h_meas_d;
            v_meas_q      <= v_meas_d;
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;
    assign h_meas      = h_meas_q;
    assign v_meas      = v_meas_q;

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Bench for vga_sync_tracker on a reduced geometry (60x13 total) with an
// active-low and an active-high instance fed from one generator.
module tb_vga_sync_tracker;

    localparam int HS = 8, HB = 6, HA = 40, HT = 60;
    localparam int VS = 2, VB = 3, VA = 6, VT = 13;
    localparam int W  = 10;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         active;
        logic         locked;
        logic         sync_err;
        logic         frame_start;
    } rec_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    logic hs0  = 1'b1;
    logic vs0  = 1'b1;
    logic hs1, vs1;

    logic [W-1:0] x0, y0, hm0, vm0, x1, y1, hm1, vm1;
    logic         act0, fs0, lk0, err0, act1, fs1, lk1, err1;

    rec_t exp_q[$];
    rec_t obs0_q[$];
    rec_t obs1_q[$];

    int n_checks   = 0;
    int n_pass     = 0;
    bit exp_locked = 1'b0;
    int fedges     = 3;

    assign hs1 = ~hs0;
    assign vs1 = ~vs0;

    always #5 pclk = ~pclk;

    vga_sync_tracker #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2), .WIDTH(W)
    ) dut_low (
        .pclk(pclk), .rst(rst), .hsync(hs0), .vsync(vs0),
        .x(x0), .y(y0), .active(act0), .frame_start(fs0), .locked(lk0),
        .sync_err(err0), .h_meas(hm0), .v_meas(vm0)
    );

    vga_sync_tracker #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
        .SYNC_POL(1'b1), .LOCK_FRAMES(2), .WIDTH(W)
    ) dut_high (
        .pclk(pclk), .rst(rst), .hsync(hs1), .vsync(vs1),
        .x(x1), .y(y1), .active(act1), .frame_start(fs1), .locked(lk1),
        .sync_err(err1), .h_meas(hm1), .v_meas(vm1)
    );

    // One pixel clock: drive the sync pair, queue what the outputs must be for
    // this sample, then capture both instances just after the edge.
    task automatic step(input bit hs_a, input bit vs_a, input int hc, input int vc,
                        input bit fs, input bit fail, input int relock_n);
        rec_t e;
        rec_t o0;
        rec_t o1;
        bit   act;
        e   = '0;
        hs0 = ~hs_a;
        vs0 = ~vs_a;
        if (!rst) begin
            if (fail) begin
                exp_locked = 1'b0;
                fedges     = relock_n;
                e.sync_err = 1'b1;
            end else if (fs && !exp_locked && fedges > 0) begin
                fedges = fedges - 1;
                if (fedges == 0) exp_locked = 1'b1;
            end
            act = exp_locked && hc >= HS + HB && hc < HS + HB + HA
                  && vc >= VS + VB && vc < VS + VB + VA;
            e.active      = act;
            e.locked      = exp_locked;
            e.frame_start = fs;
            if (act) begin
                e.x = W'(hc - (HS + HB));
                e.y = W'(vc - (VS + VB));
            end
        end
        exp_q.push_back(e);
        @(posedge pclk);
        #1;
        o0 = {x0, y0, act0, lk0, err0, fs0};
        o1 = {x1, y1, act1, lk1, err1, fs1};
        obs0_q.push_back(o0);
        obs1_q.push_back(o1);
    endtask

    task automatic gen_line(input int vc, input int len, input bit fail_first, input int relock_n);
        for (int h = 0; h < len; h++)
            step(h < HS, vc < VS, h, vc, (vc == 0 && h == 0), fail_first && h == 0, relock_n);
    endtask

    task automatic gen_frame(input int nlines, input bit fail_first, input int relock_n);
        for (int v = 0; v < nlines; v++)
            gen_line(v, HT, fail_first && v == 0, relock_n);
    endtask

    task automatic test_reset();
        rec_t e, o0, o1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, HT, VT, 1'b0, 1'b0, 0);
        n_checks++;
        if ({lk0, hm0, vm0} !== '0) $display("FAIL reset_meas locked=%0b h_meas=%0d v_meas=%0d want 0/0/0", lk0, hm0, vm0);
        else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o0 = obs0_q.pop_front(); o1 = obs1_q.pop_front();
            n_checks += 2;
            if (o0 !== e) $display("FAIL reset_low #%0d got=%h want=%h", i, o0, e); else n_pass++;
            if (o1 !== e) $display("FAIL reset_high #%0d got=%h want=%h", i, o1, e); else n_pass++;
        end
        rst = 1'b0;
        exp_locked = 1'b0;
        fedges = 3;
    endtask

    task automatic test_nominal_lock();
        rec_t e, o0, o1;
        for (int v = 3; v < VT; v++) gen_line(v, HT, 1'b0, 0);
        gen_frame(VT, 1'b0, 0);
        gen_frame(VT, 1'b0, 0);
        n_checks++;
        if (lk0 !== 1'b0) $display("FAIL early_lock locked=%0b want 0", lk0); else n_pass++;
        gen_frame(VT, 1'b0, 0);
        n_checks++;
        if (lk0 !== 1'b1 || lk1 !== 1'b1) $display("FAIL lock_acquired locked=%0b/%0b want 1/1", lk0, lk1); else n_pass++;
        n_checks++;
        if (hm0 !== W'(HT) || hm1 !== W'(HT)) $display("FAIL nominal_h_meas got=%0d/%0d want %0d", hm0, hm1, HT); else n_pass++;
        n_checks++;
        if (vm0 !== W'(VT)) $display("FAIL nominal_v_meas got=%0d want %0d", vm0, VT); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o0 = obs0_q.pop_front(); o1 = obs1_q.pop_front();
            n_checks += 2;
            if (o0 !== e) $display("FAIL nominal_low #%0d got=%h want=%h", i, o0, e); else n_pass++;
            if (o1 !== e) $display("FAIL nominal_high #%0d got=%h want=%h", i, o1, e); else n_pass++;
        end
    endtask

    task automatic test_short_line();
        rec_t e, o0, o1;
        for (int v = 0; v < 6; v++) gen_line(v, HT, 1'b0, 0);
        gen_line(6, HT - 1, 1'b0, 0);
        gen_line(7, HT, 1'b1, 3);
        n_checks++;
        if (hm0 !== W'(HT - 1)) $display("FAIL short_h_meas got=%0d want %0d", hm0, HT - 1); else n_pass++;
        n_checks++;
        if (lk0 !== 1'b0) $display("FAIL short_unlock locked=%0b want 0", lk0); else n_pass++;
        for (int v = 8; v < VT; v++) gen_line(v, HT, 1'b0, 0);
        for (int f = 0; f < 3; f++) gen_frame(VT, 1'b0, 0);
        n_checks++;
        if (lk0 !== 1'b1 || hm0 !== W'(HT)) $display("FAIL short_relock locked=%0b h_meas=%0d want 1/%0d", lk0, hm0, HT); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o0 = obs0_q.pop_front(); o1 = obs1_q.pop_front();
            n_checks += 2;
            if (o0 !== e) $display("FAIL shortline_low #%0d got=%h want=%h", i, o0, e); else n_pass++;
            if (o1 !== e) $display("FAIL shortline_high #%0d got=%h want=%h", i, o1, e); else n_pass++;
        end
    endtask

    task automatic test_short_frame();
        rec_t e, o0, o1;
        gen_frame(VT - 1, 1'b0, 0);
        gen_frame(VT, 1'b1, 2);
        n_checks++;
        if (vm0 !== W'(VT - 1) || lk0 !== 1'b0) $display("FAIL shortframe_meas v_meas=%0d locked=%0b want %0d/0", vm0, lk0, VT - 1); else n_pass++;
        gen_frame(VT, 1'b0, 0);
        n_checks++;
        if (lk0 !== 1'b0) $display("FAIL shortframe_early locked=%0b want 0", lk0); else n_pass++;
        gen_frame(VT, 1'b0, 0);
        n_checks++;
        if (lk0 !== 1'b1 || vm0 !== W'(VT)) $display("FAIL shortframe_relock locked=%0b v_meas=%0d want 1/%0d", lk0, vm0, VT); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o0 = obs0_q.pop_front(); o1 = obs1_q.pop_front();
            n_checks += 2;
            if (o0 !== e) $display("FAIL shortframe_low #%0d got=%h want=%h", i, o0, e); else n_pass++;
            if (o1 !== e) $display("FAIL shortframe_high #%0d got=%h want=%h", i, o1, e); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        rec_t e, o0, o1;
        for (int v = 0; v < 7; v++) gen_line(v, HT, 1'b0, 0);
        // hpos continues from HT after the last H-edge and saturates at 1023.
        for (int h = 0; h < 1100; h++) step(1'b0, 1'b0, HT + h, 6, 1'b0, h == 1023 - HT, 3);
        n_checks++;
        if (lk0 !== 1'b0) $display("FAIL sat_unlock locked=%0b want 0", lk0); else n_pass++;
        gen_line(7, HT, 1'b0, 0);
        n_checks++;
        if (hm0 !== W'(1023)) $display("FAIL sat_h_meas got=%0d want 1023", hm0); else n_pass++;
        for (int v = 8; v < VT; v++) gen_line(v, HT, 1'b0, 0);
        for (int f = 0; f < 3; f++) gen_frame(VT, 1'b0, 0);
        n_checks++;
        if (lk0 !== 1'b1) $display("FAIL sat_relock locked=%0b want 1", lk0); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o0 = obs0_q.pop_front(); o1 = obs1_q.pop_front();
            n_checks += 2;
            if (o0 !== e) $display("FAIL saturate_low #%0d got=%h want=%h", i, o0, e); else n_pass++;
            if (o1 !== e) $display("FAIL saturate_high #%0d got=%h want=%h", i, o1, e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_line();
        rec_t e, o0, o1;
        for (int v = 0; v < 7; v++) gen_line(v, HT, 1'b0, 0);
        for (int h = 0; h < 30; h++) step(h < HS, 1'b0, h, 7, 1'b0, 1'b0, 0);
        rst = 1'b1;
        exp_locked = 1'b0;
        fedges = 3;
        step(1'b0, 1'b0, 30, 7, 1'b0, 1'b0, 0);
        rst = 1'b0;
        n_checks++;
        if ({x0, y0, act0, lk0, err0, hm0, vm0} !== '0)
            $display("FAIL midreset_outputs x=%0d y=%0d active=%0b locked=%0b err=%0b h=%0d v=%0d want all 0",
                     x0, y0, act0, lk0, err0, hm0, vm0);
        else n_pass++;
        for (int h = 31; h < HT; h++) step(h < HS, 1'b0, h, 7, 1'b0, 1'b0, 0);
        for (int v = 8; v < VT; v++) gen_line(v, HT, 1'b0, 0);
        gen_frame(VT, 1'b0, 0);
        gen_frame(VT, 1'b0, 0);
        n_checks++;
        if (lk0 !== 1'b0) $display("FAIL midreset_early locked=%0b want 0", lk0); else n_pass++;
        gen_frame(VT, 1'b0, 0);
        n_checks++;
        if (lk0 !== 1'b1 || lk1 !== 1'b1) $display("FAIL midreset_relock locked=%0b/%0b want 1/1", lk0, lk1); else n_pass++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o0 = obs0_q.pop_front(); o1 = obs1_q.pop_front();
            n_checks += 2;
            if (o0 !== e) $display("FAIL midreset_low #%0d got=%h want=%h", i, o0, e); else n_pass++;
            if (o1 !== e) $display("FAIL midreset_high #%0d got=%h want=%h", i, o1, e); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal_lock();
        test_short_line();
        test_short_frame();
        test_saturation();
        test_reset_mid_line();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_tracker.md
# vga_sync_tracker

Receive-side companion to the VGA timing generator. Samples the hsync/vsync pair produced on the pclk domain, recovers active-area pixel coordinates, and measures line and frame lengths against the nominal timing. Declares lock only after consecutive clean frames, so downstream consumers (overlay, capture, self-check logic) can trust the coordinates. It sits between the sync outputs and any block that needs x/y without access to the generator's internal counters.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_SYNC, 96, hsync pulse width (pclk)
- H_BP, 48, horizontal back porch
- H_TOTAL, 800, nominal pclk per line
- V_ACTIVE, 480, visible lines per frame
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch
- V_TOTAL, 525, nominal lines per frame
- SYNC_POL, 0, sync active level (0 = active-low)
- LOCK_FRAMES, 2, consecutive clean frames required for lock
- WIDTH, 10, counter and coordinate width
- pclk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- hsync  in  1  horizontal sync, same domain
- vsync  in  1  vertical sync, same domain
- x  out  WIDTH  active-area column, 0 when active=0
- y  out  WIDTH  active-area row, 0 when active=0
- active  out  1  pixel inside visible area and locked
- frame_start  out  1  one-cycle pulse on frame-start line's hsync edge
- locked  out  1  timing verified
- sync_err  out  1  one-cycle pulse on any check failure while LOCKED
- h_meas  out  WIDTH  last measured line length
- v_meas  out  WIDTH  last measured frame length

## Operation
- Sync normalised by SYNC_POL; one history register per input. H-edge: hsync sampled asserted, previous sample deasserted.
- hpos: 0 on H-edge, else +1, saturating at 2^WIDTH-1 (no wrap).
- F-edge: H-edge where vsync sampled asserted and vsync at the previous H-edge deasserted. vpos: 0 on F-edge, +1 on other H-edges, saturating.
- On each H-edge: h_meas <= hpos+1 (sat.); line check passes iff h_meas == H_TOTAL. On F-edge: v_meas <= vpos+1; frame passes iff v_meas == V_TOTAL and every line check since the previous F-edge passed.
- Saturation of hpos counts as one failed line check, raised once on reaching max.
- States: SEARCH, MEASURE, LOCKED.
  - SEARCH: ignore checks; first F-edge -> MEASURE, good count 0, frame-clean flag set.
  - MEASURE: at each F-edge, passing frame increments good count; at LOCK_FRAMES -> LOCKED. Failing frame clears good count, stays MEASURE.
  - LOCKED: any failed line or frame check -> sync_err pulse, locked drops, -> MEASURE, good count 0.
- active: locked and hpos in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vpos in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE). x = hpos-(H_SYNC+H_BP), y = vpos-(V_SYNC+V_BP), both unsigned WIDTH.
- frame_start pulses on every F-edge regardless of state.

## Timing
- All outputs registered. Outputs one cycle after pclk edge k describe the sample taken at edge k.
- Reset: x=0, y=0, active=0, frame_start=0, locked=0, sync_err=0, h_meas=0, v_meas=0, state SEARCH, history registers at deasserted level, hpos/vpos 0.
- Reset mid-frame: the above values appear in the cycle after rst is sampled. Lock is reacquired only after SEARCH plus LOCK_FRAMES clean frames.
- locked rises in the cycle after the qualifying F-edge sample. Coordinates for the first line of that frame are valid.
- Failing check in LOCKED: sync_err=1 and locked=0 in the same output cycle. active drops that cycle.
- Simultaneous F-edge and line-check failure: the line failure is attributed to the ending frame, so that frame fails.

## Structure
- Shared package vga_timing_pkg: 640x480 timing constants (shared with the generator) and the state enum {SEARCH, MEASURE, LOCKED}.
- Sub-module sync_edge_detect (polarity normalise, history register, leading-edge pulse), instantiated for hsync. The vsync qualification is done at H-edges inside the top.

## Test plan
- Nominal 640x480 generator from reset -> locked rises after 1 partial frame + 2 full frames. First active pixel x=0,y=0 at hpos 144, vpos 35. Last pixel x=639,y=479. h_meas=800, v_meas=525.
- One line shortened to 799 while locked -> sync_err single pulse, locked=0, h_meas=799. Relock after 2 clean frames.
- Frame of 524 lines while locked -> sync_err at the F-edge, v_meas=524, active=0 until relock.
- hsync held deasserted 1100 cycles while locked -> hpos saturates at 1023, one sync_err pulse only, no wrap.
- rst asserted mid-active-line -> all outputs at reset values the next cycle. frame_start still pulses at the next F-edge. locked returns after 2 clean frames.
- SYNC_POL=1 with inverted stimulus -> identical x/y/locked behaviour to the nominal case.
